// File: rtl/fetch_seq_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_seq_pkg;

    localparam int PC_W   = 16;
    localparam int IMM_W  = 12;
    localparam int INSN_W = 16;

    localparam logic [PC_W-1:0] PC_STEP = 16'd2;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        HOLD,
        RESOLVE,
        HALTED
    } state_e;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Bundle of the imem, decoder and control signals around the fetch sequencer.
// The master modport is the sequencer's view; slave is the surrounding core.
interface fetch_sequencer_if;
    import fetch_seq_pkg::*;

    // Instruction-memory port
    logic              imem_req;
    logic [PC_W-1:0]   imem_addr;
    logic              imem_ack;
    logic [INSN_W-1:0] imem_rdata;

    // Decoder instruction port
    logic              ir_valid;
    logic [INSN_W-1:0] ir_data;
    logic [PC_W-1:0]   ir_pc;
    logic              ir_ready;

    // Next-PC decision from decode
    logic              br_valid;
    logic              br_taken;
    logic [IMM_W-1:0]  br_offset;
    logic              br_ready;

    // Control and status
    logic              halt;
    logic              halted;
    logic [PC_W-1:0]   pc;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        output ir_valid, ir_data, ir_pc,
        input  ir_ready,
        input  br_valid, br_taken, br_offset,
        output br_ready,
        input  halt,
        output halted, pc
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        input  ir_valid, ir_data, ir_pc,
        output ir_ready,
        output br_valid, br_taken, br_offset,
        input  br_ready,
        output halt,
        input  halted, pc
    );

endinterface

// File: rtl/branch_imm_ext.sv
// Sign-extends a 12-bit halfword offset and scales it to a 16-bit byte
// displacement. Purely combinational so the ALU immediate path can share it.
module branch_imm_ext
    import fetch_seq_pkg::*;
(
    input  logic [IMM_W-1:0] imm_i,
    output logic [PC_W-1:0]  disp_o
);

    assign disp_o = {{(PC_W-IMM_W-1){imm_i[IMM_W-1]}}, imm_i, 1'b0};

endmodule

// File: rtl/fetch_sequencer.sv
// Program-counter owner: fetches one instruction, hands it to decode, waits
// for the next-PC decision, then fetches again. All outputs are registers.
module fetch_sequencer
    import fetch_seq_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 16'h0000
) (
    input  logic              clk,
    input  logic              rst_n,
    fetch_sequencer_if.master bus
);

    state_e              state_q;
    logic [PC_W-1:0]     pc_q;
    logic                imem_req_q;
    logic [PC_W-1:0]     imem_addr_q;
    logic                ir_valid_q;
    logic [INSN_W-1:0]   ir_data_q;
    logic [PC_W-1:0]     ir_pc_q;
    logic                br_ready_q;
    logic                halted_q;

    logic [PC_W-1:0]     br_disp;
    logic [PC_W-1:0]     pc_d;

    branch_imm_ext u_imm_ext (
        .imm_i  (bus.br_offset),
        .disp_o (br_disp)
    );

    // Candidate next PC, relative to the instruction being resolved; the sum
    // wraps modulo 2^16 by construction.
    always_comb begin
        // NOTE: pc_d gets a value on every path before any condition so no latch is inferred.
        pc_d = ir_pc_q + PC_STEP;
        if (bus.br_taken) begin
            pc_d = ir_pc_q + br_disp;
        end
    end

    // Sequencer FSM with registered outputs; each handshake advances one state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            imem_req_q  <= 1'b0;
            imem_addr_q <= '0;
            ir_valid_q  <= 1'b0;
            ir_data_q   <= '0;
            ir_pc_q     <= '0;
            br_ready_q  <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            unique case (state_q)
                IDLE: begin
                    if (bus.halt) begin
                        state_q  <= HALTED;
                        halted_q <= 1'b1;
                    end else begin
                        state_q     <= FETCH;
                        imem_req_q  <= 1'b1;
                        imem_addr_q <= pc_q;
                    end
                end

                // halt is deliberately not looked at here: a request in
                // flight always completes.
                FETCH: begin
                    if (bus.imem_ack) begin
                        imem_req_q <= 1'b0;
                        ir_data_q  <= bus.imem_rdata;
                        ir_pc_q    <= pc_q;
                        ir_valid_q <= 1'b1;
                        state_q    <= HOLD;
                    end
                end

                HOLD: begin
                    if (bus.ir_ready) begin
                        ir_valid_q <= 1'b0;
                        br_ready_q <= 1'b1;
                        state_q    <= RESOLVE;
                    end
                end

                // The new PC goes straight onto imem_addr so the next request
                // is visible in the cycle after the decision handshake.
                RESOLVE: begin
                    if (bus.br_valid) begin
                        pc_q       <= pc_d;
                        br_ready_q <= 1'b0;
                        if (bus.halt) begin
                            state_q  <= HALTED;
                            halted_q <= 1'b1;
                        end else begin
                            state_q     <= FETCH;
                            imem_req_q  <= 1'b1;
                            imem_addr_q <= pc_d;
                        end
                    end
                end

                HALTED: begin
                    halted_q <= 1'b1;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.imem_req  = imem_req_q;
    assign bus.imem_addr = imem_addr_q;
    assign bus.ir_valid  = ir_valid_q;
    assign bus.ir_data   = ir_data_q;
    assign bus.ir_pc     = ir_pc_q;
    assign bus.br_ready  = br_ready_q;
    assign bus.halted    = halted_q;
    assign bus.pc        = pc_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: each next-PC decision pushes the
// expected fetch address, which is popped when the DUT raises imem_req.
module tb_fetch_sequencer;
    import fetch_seq_pkg::*;

    localparam logic [15:0] RESET_PC = 16'h0000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    fetch_sequencer_if bus ();

    fetch_sequencer #(.RESET_PC(RESET_PC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          errors   = 0;
    int          cyc      = 0;
    int          rise_cnt = 0;
    logic        req_prev = 1'b0;
    logic [15:0] addr_q[$];
    bit          need_pop = 1'b0;
    logic [15:0] cur_pc   = 16'h0000;

    // Cycle counter for throughput measurements.
    always @(posedge clk) cyc <= cyc + 1;

    // Counts imem_req rising edges, i.e. distinct fetches started.
    always @(negedge clk) begin
        if (bus.imem_req === 1'b1 && req_prev !== 1'b1) rise_cnt <= rise_cnt + 1;
        req_prev <= bus.imem_req;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset(input bit halt_val);
        rst_n          = 1'b0;
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 16'h0000;
        bus.ir_ready   = 1'b0;
        bus.br_valid   = 1'b0;
        bus.br_taken   = 1'b0;
        bus.br_offset  = 12'h000;
        bus.halt       = halt_val;
        addr_q.delete();
        addr_q.push_back(RESET_PC);
        need_pop = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Drives one full instruction: fetch (with ack delay), hold (with ready
    // delay and optional stray br_valid), then the next-PC decision.
    task automatic run_instr(input int ack_dly, input int rdy_dly, input bit taken,
                             input logic [11:0] off, input bit bogus, input bit halt_now,
                             output int next_cyc);
        logic [15:0] exp_addr;
        logic [15:0] word;
        logic [15:0] target;
        int          s;
        int          budget;
        next_cyc = 0;
        if (need_pop) begin
            budget = 0;
            while (bus.imem_req !== 1'b1 && budget < 20) begin
                tick();
                budget++;
            end
            exp_addr = (addr_q.size() != 0) ? addr_q.pop_front() : 16'hxxxx;
            checks++;
            if (bus.imem_req !== 1'b1 || bus.imem_addr !== exp_addr || bus.pc !== exp_addr) begin
                errors++;
                $display("FAIL fetch_start: req=%b addr=%h pc=%h, expected req=1 addr=pc=%h",
                         bus.imem_req, bus.imem_addr, bus.pc, exp_addr);
            end
            cur_pc   = exp_addr;
            need_pop = 1'b0;
        end
        if (halt_now) bus.halt = 1'b1;

        for (int i = 0; i < ack_dly; i++) begin
            tick();
            checks++;
            if (bus.imem_req !== 1'b1 || bus.imem_addr !== cur_pc) begin
                errors++;
                $display("FAIL fetch_hold: req=%b addr=%h, expected req=1 addr=%h",
                         bus.imem_req, bus.imem_addr, cur_pc);
            end
        end

        word           = 16'($urandom);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = word;
        tick();
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = ~word;
        checks++;
        if (bus.ir_valid !== 1'b1 || bus.ir_data !== word || bus.ir_pc !== cur_pc || bus.imem_req !== 1'b0) begin
            errors++;
            $display("FAIL ir_present: valid=%b data=%h pc=%h req=%b, expected 1 %h %h 0",
                     bus.ir_valid, bus.ir_data, bus.ir_pc, bus.imem_req, word, cur_pc);
        end

        if (bogus) begin
            bus.br_valid  = 1'b1;
            bus.br_taken  = 1'b1;
            bus.br_offset = 12'h100;
            tick();
            bus.br_valid  = 1'b0;
            bus.br_taken  = 1'b0;
            checks++;
            if (bus.ir_valid !== 1'b1 || bus.imem_req !== 1'b0 || bus.br_ready !== 1'b0 || bus.pc !== cur_pc) begin
                errors++;
                $display("FAIL hold_ignores_br: valid=%b req=%b br_ready=%b pc=%h, expected 1 0 0 %h",
                         bus.ir_valid, bus.imem_req, bus.br_ready, bus.pc, cur_pc);
            end
        end

        for (int i = 0; i < rdy_dly; i++) begin
            tick();
            checks++;
            if (bus.ir_valid !== 1'b1 || bus.ir_data !== word || bus.ir_pc !== cur_pc) begin
                errors++;
                $display("FAIL ir_hold: valid=%b data=%h pc=%h, expected 1 %h %h",
                         bus.ir_valid, bus.ir_data, bus.ir_pc, word, cur_pc);
            end
        end

        bus.ir_ready = 1'b1;
        tick();
        bus.ir_ready = 1'b0;
        checks++;
        if (bus.ir_valid !== 1'b0 || bus.br_ready !== 1'b1) begin
            errors++;
            $display("FAIL resolve_enter: valid=%b br_ready=%b, expected 0 1",
                     bus.ir_valid, bus.br_ready);
        end

        s = int'(off);
        if (s >= 2048) s -= 4096;
        target = taken ? 16'(int'(cur_pc) + 2 * s) : 16'(int'(cur_pc) + 2);
        if (!halt_now) addr_q.push_back(target);

        bus.br_valid  = 1'b1;
        bus.br_taken  = taken;
        bus.br_offset = off;
        tick();
        bus.br_valid  = 1'b0;
        bus.br_taken  = 1'b0;
        checks++;
        if (bus.pc !== target || bus.br_ready !== 1'b0) begin
            errors++;
            $display("FAIL pc_update: ir_pc=%h off=%h taken=%b pc=%h br_ready=%b, expected pc=%h br_ready=0",
                     cur_pc, off, taken, bus.pc, bus.br_ready, target);
        end
        next_cyc = cyc;

        if (halt_now) begin
            checks++;
            if (bus.halted !== 1'b1 || bus.imem_req !== 1'b0) begin
                errors++;
                $display("FAIL halt_enter: halted=%b req=%b, expected 1 0", bus.halted, bus.imem_req);
            end
        end else begin
            exp_addr = (addr_q.size() != 0) ? addr_q.pop_front() : 16'hxxxx;
            checks++;
            if (bus.imem_req !== 1'b1 || bus.imem_addr !== exp_addr) begin
                errors++;
                $display("FAIL next_fetch: req=%b addr=%h, expected req=1 addr=%h",
                         bus.imem_req, bus.imem_addr, exp_addr);
            end
            cur_pc = exp_addr;
        end
    endtask

    task automatic test_reset();
        int d;
        do_reset(1'b0);
        run_instr(0, 0, 1'b1, 12'h010, 1'b0, 1'b0, d);   // now mid-FETCH at 0020
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.imem_req !== 1'b0 || bus.imem_addr !== 16'h0000 || bus.ir_valid !== 1'b0 ||
            bus.ir_data !== 16'h0000 || bus.ir_pc !== 16'h0000 || bus.br_ready !== 1'b0 ||
            bus.halted !== 1'b0 || bus.pc !== RESET_PC) begin
            errors++;
            $display("FAIL reset_outputs: req=%b addr=%h valid=%b data=%h ir_pc=%h br_ready=%b halted=%b pc=%h, expected all 0",
                     bus.imem_req, bus.imem_addr, bus.ir_valid, bus.ir_data, bus.ir_pc,
                     bus.br_ready, bus.halted, bus.pc);
        end
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 16'hBEEF;
        tick();
        tick();
        checks++;
        if (bus.ir_valid !== 1'b0 || bus.ir_data !== 16'h0000 || bus.imem_req !== 1'b0) begin
            errors++;
            $display("FAIL stale_ack: valid=%b data=%h req=%b, expected 0 0000 0",
                     bus.ir_valid, bus.ir_data, bus.imem_req);
        end
        bus.imem_ack = 1'b0;
        rst_n        = 1'b1;
        #1;
        checks++;
        if (bus.imem_req !== 1'b0) begin
            errors++;
            $display("FAIL idle_cycle: req=%b, expected 0", bus.imem_req);
        end
        tick();
        checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== RESET_PC || bus.ir_valid !== 1'b0) begin
            errors++;
            $display("FAIL first_fetch: req=%b addr=%h valid=%b, expected 1 %h 0",
                     bus.imem_req, bus.imem_addr, bus.ir_valid, RESET_PC);
        end
    endtask

    task automatic test_sequential();
        int c1, c2, c3;
        do_reset(1'b0);
        run_instr(0, 0, 1'b0, 12'h000, 1'b0, 1'b0, c1);
        run_instr(0, 0, 1'b0, 12'h000, 1'b0, 1'b0, c2);
        run_instr(0, 0, 1'b0, 12'h000, 1'b0, 1'b0, c3);
        checks++;
        if (c2 - c1 != 3 || c3 - c2 != 3) begin
            errors++;
            $display("FAIL throughput: fetch intervals %0d %0d cycles, expected 3 3", c2 - c1, c3 - c2);
        end
    endtask

    task automatic test_branches();
        // {taken, offset}: walks 0000->0010->001A->0010->0008->0000->F000
        // ->FFFE->0FFC->FFFE->0000 (last one not taken).
        logic [12:0] tbl [10] = '{13'h1008, 13'h1005, 13'h1FFB, 13'h1FFC, 13'h1FFC,
                                   13'h1800, 13'h17FF, 13'h17FF, 13'h1801, 13'h07FF};
        int d;
        do_reset(1'b0);
        foreach (tbl[i]) begin
            run_instr(0, 0, tbl[i][12], tbl[i][11:0], 1'b0, 1'b0, d);
        end
    endtask

    task automatic test_backpressure();
        int d;
        int base;
        do_reset(1'b0);
        base = rise_cnt;
        run_instr(3, 2, 1'b0, 12'h000, 1'b1, 1'b0, d);
        checks++;
        if (rise_cnt - base != 2) begin
            errors++;
            $display("FAIL one_fetch_per_instr: %0d fetches started, expected 2", rise_cnt - base);
        end
        run_instr(1, 1, 1'b1, 12'hFFF, 1'b1, 1'b0, d);
    endtask

    task automatic test_halt_fetch();
        int d;
        do_reset(1'b0);
        run_instr(1, 0, 1'b1, 12'h010, 1'b0, 1'b1, d);
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (bus.imem_req !== 1'b0 || bus.halted !== 1'b1 || bus.pc !== 16'h0020) begin
                errors++;
                $display("FAIL halted_quiet: req=%b halted=%b pc=%h, expected 0 1 0020",
                         bus.imem_req, bus.halted, bus.pc);
            end
        end
        bus.halt = 1'b0;
        tick();
        tick();
        checks++;
        if (bus.halted !== 1'b1 || bus.imem_req !== 1'b0) begin
            errors++;
            $display("FAIL halted_sticky: halted=%b req=%b, expected 1 0", bus.halted, bus.imem_req);
        end
    endtask

    task automatic test_halt_reset();
        int base;
        do_reset(1'b1);
        base = rise_cnt;
        tick();
        checks++;
        if (bus.halted !== 1'b1 || bus.imem_req !== 1'b0) begin
            errors++;
            $display("FAIL halt_at_release: halted=%b req=%b, expected 1 0", bus.halted, bus.imem_req);
        end
        for (int i = 0; i < 6; i++) tick();
        checks++;
        if (rise_cnt != base || bus.halted !== 1'b1) begin
            errors++;
            $display("FAIL halt_no_fetch: %0d fetches halted=%b, expected 0 fetches halted=1",
                     rise_cnt - base, bus.halted);
        end
        bus.halt = 1'b0;
    endtask

    initial begin
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 16'h0000;
        bus.ir_ready   = 1'b0;
        bus.br_valid   = 1'b0;
        bus.br_taken   = 1'b0;
        bus.br_offset  = 12'h000;
        bus.halt       = 1'b0;
        test_reset();
        test_sequential();
        test_branches();
        test_backpressure();
        test_halt_fetch();
        test_halt_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch and PC sequencing controller for the 16-bit RISC core. Owns the program counter, issues fetch requests to instruction memory, presents each fetched instruction to the decoder, and applies the next-PC decision returned by decode. Taken branches use the 12-bit PC-relative offset after sign-extension and a left shift by 1, producing a 16-bit byte displacement. The block sits between the instruction-memory port and the decode stage.

## Interface
- RESET_PC, 16'h0000, PC value loaded on reset.
- clk  in  1  core clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request; held until imem_ack.
- imem_addr  out  16  fetch byte address; stable while imem_req=1.
- imem_ack  in  1  memory returns imem_rdata this cycle.
- imem_rdata  in  16  fetched instruction word.
- ir_valid  out  1  instruction available to decoder.
- ir_data  out  16  held instruction word.
- ir_pc  out  16  address of the held instruction.
- ir_ready  in  1  decoder accepts ir_data.
- br_valid  in  1  decoder presents the next-PC decision.
- br_taken  in  1  1: branch taken; 0: fall through.
- br_offset  in  12  signed offset in halfwords.
- br_ready  out  1  sequencer accepts the decision.
- halt  in  1  stop-fetch request, level-sensitive.
- halted  out  1  sequencer stopped; sticky until reset.
- pc  out  16  current program counter.

## Operation
- States: IDLE, FETCH, HOLD, RESOLVE, HALTED.
- Reset, asynchronous:
  - State → IDLE; pc → RESET_PC.
  - imem_req, imem_addr, ir_valid, ir_data, ir_pc, br_ready, halted → 0.
  - Reset mid-transaction abandons it; a late imem_ack is ignored.
- IDLE:
  - halt=1 → HALTED.
  - Otherwise → FETCH.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - On imem_ack: ir_data←imem_rdata, ir_pc←pc, ir_valid←1, → HOLD.
  - halt does not abort an outstanding request.
- HOLD:
  - ir_valid=1; ir_data and ir_pc stay stable.
  - On ir_ready: ir_valid←0, → RESOLVE.
- RESOLVE:
  - br_ready=1.
  - On br_valid with br_taken=1: pc←ir_pc + ext(br_offset).
  - On br_valid with br_taken=0: pc←ir_pc + 2.
  - Then → HALTED if halt=1, else → FETCH.
  - Every instruction is resolved; non-branch instructions return br_taken=0.
- HALTED: halted=1, no requests; exits only on reset.
- Offset extension: ext(o) = {o[11], o[11], o[11], o[11:0], 1'b0}. Range is −4096..+4094 bytes.
- Arithmetic is modulo 2^16; 16'hFFFE+2 wraps to 16'h0000, and no overflow flag is produced.
- Out-of-state inputs are ignored:
  - imem_ack outside FETCH.
  - ir_ready outside HOLD.
  - br_valid outside RESOLVE.

## Timing
- All outputs are registered; no combinational input→output paths.
- imem_req rises one cycle after reset release (one IDLE cycle).
- imem_ack may arrive in the first cycle of imem_req; FETCH then lasts 1 cycle.
- Minimum throughput is one instruction per 3 cycles: FETCH, HOLD, RESOLVE.
- The new pc is visible, and imem_req with the new address is asserted, in the cycle after the br_valid handshake.
- Handshakes complete when valid and ready are both high at a rising edge. Held data must not change while waiting.

## Structure
- Package fetch_seq_pkg holds:
  - the state enum;
  - PC_W=16, IMM_W=12, PC_STEP=16'd2.
- Sub-module branch_imm_ext: combinational 12→16 sign-extend-and-shift implementing ext(). It is instantiated once for the target adder and reusable by the ALU immediate path.

## Test plan
- Reset mid-FETCH with RESET_PC=16'h0000:
  - All outputs are 0 immediately.
  - After release, one idle cycle, then imem_req=1 with imem_addr=16'h0000.
  - A stale imem_ack during reset is ignored.
- Sequential run, immediate ack/ready and br_taken=0:
  - Fetch addresses are 0000, 0002, 0004.
  - A new imem_req rises every 3 cycles.
- Forward branch, ir_pc=16'h0010, br_offset=12'h005, taken → next imem_addr=16'h001A.
- Backward branch and extension corners, all taken:
  - ir_pc=0010, offset=FFC → 0008.
  - ir_pc=0000, offset=800 → F000.
  - ir_pc=FFFE, offset=7FF → 0FFC.
  - ir_pc=FFFE, not taken → 0000.
- Backpressure:
  - With imem_ack delayed 3 cycles, imem_addr holds.
  - With ir_ready low 2 cycles, ir_data and ir_pc hold.
  - A br_valid pulse during HOLD is ignored, and exactly one fetch occurs per instruction.
- Halt:
  - halt=1 during FETCH: the fetch completes, HOLD and RESOLVE proceed, then halted=1 with pc updated and no further imem_req.
  - halt=1 at reset release: IDLE → HALTED with zero fetches.
